// File: rtl/fp_to_tc_if.sv
// Handshake bundle for the 8-bit float to two's-complement decoder.
// The slave modport is the decoder side; the master modport is the producer/consumer side.
interface fp_to_tc_if #(
   parameter int EXP_W  = 3,
   parameter int FRAC_W = 4,
   parameter int OUT_W  = 12
);
   logic              in_valid;
   logic              in_ready;
   logic              S;
   logic [EXP_W-1:0]  E;
   logic [FRAC_W-1:0] F;
   logic              out_valid;
   logic              out_ready;
   logic [OUT_W-1:0]  D;
   logic              busy;

   modport slave (
      input  in_valid, S, E, F, out_ready,
      output in_ready, out_valid, D, busy
   );

   modport master (
      output in_valid, S, E, F, out_ready,
      input  in_ready, out_valid, D, busy
   );
endinterface

// File: rtl/fp_to_tc.sv
// Iterative decoder: D = (-1)^S * (F << E), one left shift per clock, then sign.
// Accepts one request in IDLE and holds the result in DONE until it is taken.
module fp_to_tc #(
   parameter int EXP_W  = 3,
   parameter int FRAC_W = 4,
   parameter int OUT_W  = 12
) (
   input  logic        clk,
   input  logic        rst_n,
   fp_to_tc_if.slave   bus
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t            state_q, state_d;
   logic [OUT_W-2:0]  mag_q, mag_d;
   logic [EXP_W-1:0]  cnt_q, cnt_d;
   logic              sign_q, sign_d;
   logic [OUT_W-1:0]  d_q, d_d;
   logic [OUT_W-1:0]  mag_ext;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         mag_q   <= '0;
         cnt_q   <= '0;
         sign_q  <= 1'b0;
         d_q     <= '0;
      end else begin
         state_q <= state_d;
         mag_q   <= mag_d;
         cnt_q   <= cnt_d;
         sign_q  <= sign_d;
         d_q     <= d_d;
      end
   end

   // Zero-extend before negating so the largest magnitude maps onto a legal negative code.
   assign mag_ext = {1'b0, mag_q};

   always_comb begin
      state_d = state_q;
      mag_d   = mag_q;
      cnt_d   = cnt_q;
      sign_d  = sign_q;
      d_d     = d_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               mag_d   = (OUT_W-1)'(bus.F);
               cnt_d   = bus.E;
               sign_d  = bus.S;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (cnt_q != '0) begin
               mag_d = mag_q << 1;
               cnt_d = cnt_q - EXP_W'(1);
            end else begin
               d_d     = sign_q ? (~mag_ext + OUT_W'(1)) : mag_ext;
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = (state_q == IDLE);
      bus.out_valid = (state_q == DONE);
      bus.busy      = (state_q != IDLE);
      bus.D         = d_q;
   end
endmodule

// File: tb/tb_fp_to_tc.sv
// Directed bench for fp_to_tc: expected words are queued at the accepting edge
// and compared when the output handshake happens.
module tb_fp_to_tc;
   localparam int EXP_W  = 3;
   localparam int FRAC_W = 4;
   localparam int OUT_W  = 12;

   typedef struct {
      logic [OUT_W-1:0] d;
      int               lat;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;
   exp_t sb[$];

   fp_to_tc_if #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .OUT_W(OUT_W)) bus ();

   fp_to_tc #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .OUT_W(OUT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Independent reference: signed integer arithmetic, truncated to the output width.
   function automatic exp_t model(input logic s, input int e, input int f);
      exp_t r;
      int   v;
      logic [31:0] w;
      v     = f * (1 << e);
      if (s) v = -v;
      w     = v;
      r.d   = w[OUT_W-1:0];
      r.lat = e + 2;
      return r;
   endfunction

   // One request; hold = cycles of backpressure in DONE; early = out_ready high from accept.
   task automatic txn(input logic s, input int e, input int f, input int hold, input logic early);
      exp_t ex;
      int   edges;
      check("in_ready_before_accept", bus.in_ready, 1);
      bus.in_valid = 1'b1;
      bus.S = s;
      bus.E = e[EXP_W-1:0];
      bus.F = f[FRAC_W-1:0];
      sb.push_back(model(s, e, f));
      step();
      edges = 1;
      bus.in_valid = 1'b0;
      bus.S = ~s;
      bus.E = EXP_W'($urandom);
      bus.F = FRAC_W'($urandom);
      bus.out_ready = early;
      while (!bus.out_valid && edges < 20) begin
         check("in_ready_low_busy", bus.in_ready, 0);
         check("busy_high", bus.busy, 1);
         step();
         edges++;
      end
      ex = sb.pop_front();
      check("latency_edges", edges, ex.lat);
      if (!bus.out_valid) begin
         rst_n = 1'b0;
         step();
         rst_n = 1'b1;
         bus.out_ready = 1'b0;
         return;
      end
      if (!early) begin
         for (int i = 0; i < hold; i++) begin
            check("held_D", bus.D, ex.d);
            check("held_out_valid", bus.out_valid, 1);
            check("in_ready_in_done", bus.in_ready, 0);
            step();
         end
      end
      check("D_value", bus.D, ex.d);
      $display("txn S=%0d E=%0d F=%0d D=%03h expected=%03h latency=%0d", s, e, f, bus.D, ex.d, edges);
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      check("out_valid_cleared", bus.out_valid, 0);
      check("in_ready_after_out", bus.in_ready, 1);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      bus.in_valid  = 1'b1;
      bus.S = 1'b0;
      bus.E = 3'd1;
      bus.F = 4'd3;
      bus.out_ready = 1'b0;
      step();
      step();
      check("reset_in_ready", bus.in_ready, 1);
      check("reset_out_valid", bus.out_valid, 0);
      check("reset_D", bus.D, 0);
      check("reset_busy", bus.busy, 0);
      bus.in_valid = 1'b0;
      rst_n = 1'b1;
      step();
      check("idle_no_request", bus.busy, 0);

      txn(1'b0, 0, 1, 0, 1'b0);
      txn(1'b0, 7, 15, 0, 1'b0);
      txn(1'b1, 7, 15, 0, 1'b0);
      txn(1'b1, 3, 5, 0, 1'b1);
      txn(1'b1, 5, 0, 0, 1'b0);
      txn(1'b0, 2, 9, 5, 1'b0);
      txn(1'b1, 4, 11, 0, 1'b0);

      // Abort mid-shift: the partial result must not surface.
      bus.in_valid = 1'b1;
      bus.S = 1'b1;
      bus.E = 3'd6;
      bus.F = 4'd13;
      step();
      bus.in_valid = 1'b0;
      step();
      step();
      check("shift_busy_before_abort", bus.busy, 1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("abort_in_ready", bus.in_ready, 1);
      check("abort_out_valid", bus.out_valid, 0);
      check("abort_D", bus.D, 0);
      check("abort_busy", bus.busy, 0);
      for (int i = 0; i < 8; i++) step();
      check("abort_stays_idle", bus.out_valid, 0);

      for (int s = 0; s < 2; s++)
         for (int e = 0; e < 8; e++)
            for (int f = 0; f < 16; f++)
               txn(s[0], e, f, 0, f[0]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
